// File: rtl/byte_serial_adder.sv
// byte_serial_adder: multi-byte unsigned adder built around one 8-bit
// carry-lookahead adder. One byte is added per clock, LSB byte first, and
// the carry is registered between bytes. Result and carry-out are
// registered and held until the next completion.
// Optional feature macro: BYTE_SERIAL_ADDER_OVERFLOW_EN adds the 'ovf'
// output (two's-complement signed overflow of the completed addition).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; sum/cout hold the last result
//   RUN   | adding byte idx of the latched operands each cycle

module carrylookahead_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Generate/propagate terms and the carry chain expanded from them
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic          carry;
  logic [IW-1:0] idx;

  logic [7:0]    cla_a;
  logic [7:0]    cla_b;
  logic [7:0]    cla_sum;
  logic          cla_cout;

  // Select the current byte of each latched operand for the shared CLA
  always_comb begin
    cla_a = op_a[idx*8 +: 8];
    cla_b = op_b[idx*8 +: 8];
  end

  carrylookahead_adder_8bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Accumulator with the current byte's sum merged in, so the final byte
  // is already present when the full result is copied to sum
  always_comb begin
    acc_next             = acc;
    acc_next[idx*8 +: 8] = cla_sum;
  end

  // Sequencing FSM with registered busy/done/sum/cout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= cla_cout;
          if (idx == LAST_IDX) begin
            sum   <= acc_next;
            cout  <= cla_cout;
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
            // carry into MSB xor carry out of MSB
            ovf   <= op_a[W-1] ^ op_b[W-1] ^ cla_sum[7] ^ cla_cout;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder (NBYTES=4). Stimulus pushes the
// expected result and completion cycle; a monitor pops on every done.
module tb_byte_serial_adder;

  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic and signed-overflow rule
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int when);
    exp_t e;
    logic [W:0] r;
    r     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.res = r;
    e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    e.cyc = when;
    return e;
  endfunction

  // Monitor: every done pops one expected result
  always @(negedge clk) begin
    if (!rst) begin
      if (done && busy) chk("done_and_busy", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.res[W-1:0]));
          chk("cout", 64'(cout), 64'(e.res[W]));
          chk("latency_cycle", 64'(cyc), 64'(e.cyc));
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
          chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Issue one request at a negedge; optionally track it in the scoreboard.
  // Inputs are scrambled after acceptance to prove they were latched.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit track);
    wait_idle();
    a_i   = a;
    b_i   = b;
    cin_i = c;
    start = 1'b1;
    if (track) q.push_back(model(a, b, c, cyc + 1 + NBYTES));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    cin_i = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 1, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    cin_i = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;  // rst wins over start
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_sum", 64'(sum), 0);
    chk("reset_cout", 64'(cout), 0);
`ifdef BYTE_SERIAL_ADDER_OVERFLOW_EN
    chk("reset_ovf", 64'(ovf), 0);
`endif

    // zero operands; busy must be high throughout the run
    start_op('0, '0, 1'b0, 1'b1);
    for (int i = 1; i < NBYTES; i++) begin
      chk("busy_during_run", 64'(busy), 1);
      @(negedge clk);
    end
    start_op(32'h12345678, 32'h11111111, 1'b1, 1'b1);
    start_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);

    // start while busy ignored, then start in the done cycle accepted
    start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1);
    a_i   = 32'hDEADBEEF;
    b_i   = 32'h0BADF00D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    a_i   = 32'd1;
    b_i   = 32'd2;
    cin_i = 1'b0;
    start = 1'b1;
    q.push_back(model(32'd1, 32'd2, 1'b0, cyc + 1 + NBYTES));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done_start", 64'(busy), 1);

    // abort mid-operation with reset
    start_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_sum", 64'(sum), 0);
    chk("abort_cout", 64'(cout), 0);
    repeat (NBYTES + 2) @(negedge clk);
    chk("abort_no_done", 64'(done), 0);
    start_op(32'd5, 32'd7, 1'b0, 1'b1);

    // signed overflow corners
    start_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
    start_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
    start_op(32'h80000000, 32'h80000000, 1'b0, 1'b1);

    // random traffic, sometimes back-to-back in the done cycle
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        a_i   = $urandom;
        b_i   = $urandom;
        cin_i = 1'($urandom);
        start = 1'b1;
        q.push_back(model(a_i, b_i, cin_i, cyc + 1 + NBYTES));
        @(negedge clk);
        start = 1'b0;
      end else begin
        start_op($urandom, $urandom, 1'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serial_adder.md
Name: byte_serial_adder

Overview:
- Multi-byte adder that reuses one instance of the team's existing combinational 8-bit carry-lookahead adder, `carrylookahead_adder_8bit` (ports a, b, cin, sum, cout).
- Processes one byte per clock, LSB byte first, and registers the carry between bytes.
- Sits directly around the 8-bit CLA: it feeds the CLA's a/b/cin and consumes its sum/cout.
- Gives wide additions at 8-bit CLA area cost, for datapaths that can tolerate multi-cycle latency.

Parameters:
- NBYTES, 4, number of bytes per operand. Operand width W = 8*NBYTES. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request. Sampled only when busy=0.
- a  input  W  operand A. Captured on an accepted start.
- b  input  W  operand B. Captured on an accepted start.
- cin  input  1  carry-in to byte 0. Captured on an accepted start.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse marking a valid result.
- sum  output  W  registered result. Holds its value until the next completion.
- cout  output  1  registered carry-out of the MSB byte.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry, accumulator and byte index registers cleared.
- FSM has two states, IDLE and RUN.
- IDLE:
  - If start=1 at an edge: latch a, b, cin; set idx=0; go to RUN; busy=1 from the next cycle.
  - If start=0: stay in IDLE; sum and cout keep their last values.
- RUN, each cycle:
  - CLA inputs are byte idx of latched A, byte idx of latched B, and the carry register.
  - At the edge: CLA sum is written into byte idx of the accumulator; CLA cout goes into the carry register; idx increments.
- Completion, at the edge where idx=NBYTES-1:
  - The full accumulator (including the final byte) is written to sum; final CLA cout is written to cout.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+NBYTES, i.e. exactly NBYTES cycles of busy=1.
- start while busy=1: ignored entirely. No queueing; operands unchanged.
- start in the done cycle: accepted, since busy=0 there. Back-to-back throughput is one result per NBYTES+1 cycles. sum/cout keep the previous result until the next completion.
- Inputs a/b/cin may change freely after acceptance without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(W+1). No saturation.
- rst mid-operation: abort immediately. Go to reset values; no done pulse; the partial result is discarded.
- rst and start in the same cycle: rst wins; start is not accepted.
- done and busy are never high together.

Optional Feature:
- Macro: BYTE_SERIAL_ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port `ovf`, 1 bit, reset 0.
  - Updated only at completion to carry-into-MSB-bit XOR carry-out-of-MSB-bit, computed from the final byte as a[W-1]^b[W-1]^sum_bit[W-1]^cout. This gives two's-complement signed overflow.
  - Held otherwise.
- When undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- Reset, then start with a=0, b=0, cin=0 -> busy high for 4 cycles, then done pulse; sum=0x00000000, cout=0.
- a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0, done exactly 4 cycles after start.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> carry ripples through all bytes: sum=0x00000000, cout=1.
- Start a=0x000000FF, b=0x00000001, cin=0, then pulse start with different operands while busy -> second request ignored; sum=0x00000100. Then start asserted in the done cycle with a=1, b=2 -> accepted; sum=0x00000003 four cycles later.
- Start a=0xAAAAAAAA, b=0x55555555, assert rst after 2 RUN cycles -> no done pulse; busy=0, sum=0, cout=0. A later start with a=5, b=7 gives sum=0x0000000C.
- With BYTE_SERIAL_ADDER_OVERFLOW_EN: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0.
